// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the SRAM-like two-port arbiter: requester ids,
// grant FSM encoding and the fixed instruction fetch size.
package sram_like_arbiter_pkg;

  localparam logic ARB_ID_INST = 1'b0;
  localparam logic ARB_ID_DATA = 1'b1;

  localparam logic [1:0] ARB_INST_SIZE = 2'd2;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/sram_like_arbiter_order_fifo.sv
// Order FIFO for the arbiter: remembers which port owns each accepted
// request. One extra "reserve" flag accounts for a grant that is held
// waiting for addr_ok, so it always finds a free slot when it completes.
module arb_order_fifo
  import sram_like_arbiter_pkg::*;
#(
  parameter int OUTST_DEPTH = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic pop,
  input  logic din,
  input  logic reserve,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int PW = $clog2(OUTST_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(OUTST_DEPTH);

  logic [OUTST_DEPTH-1:0] mem_q;
  logic [PW-1:0]          wptr_q, wptr_d;
  logic [PW-1:0]          rptr_q, rptr_d;
  logic [PW:0]            cnt_q, cnt_d;
  logic [PW:0]            occ;
  logic                   rsv_q, rsv_d;
  logic                   do_pop;

  // Occupancy counts stored entries plus a pending reserved slot.
  assign empty  = (cnt_q == '0);
  assign occ    = cnt_q + {{PW{1'b0}}, rsv_q};
  assign full   = (occ == DEPTH_C);
  assign dout   = mem_q[rptr_q];
  assign do_pop = pop & ~empty;

  // Next-state for pointers, entry count and the reservation flag.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    rsv_d  = rsv_q;
    if (push) begin
      wptr_d = wptr_q + 1'b1;
      rsv_d  = 1'b0;
    end
    if (reserve) begin
      rsv_d = 1'b1;
    end
    if (do_pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state register; reset discards every outstanding entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      rsv_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      rsv_q  <= rsv_d;
    end
  end

  // Entry storage; contents are only meaningful below the count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= din;
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like memory port between the instruction requester
// (port 0) and the data requester (port 1). Grants are held until
// m_addr_ok; responses are routed back in acceptance order.
// Optional macro ARB_RR_EN: round-robin selection instead of fixed
// data-over-instruction priority.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int OUTST_DEPTH = 4,
  parameter int AW          = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_addr_ok,
  output logic          i_data_ok,
  output logic [31:0]   i_rdata,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [1:0]    d_size,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_addr_ok,
  output logic          d_data_ok,
  output logic [31:0]   d_rdata,
  output logic          m_req,
  output logic          m_wr,
  output logic [1:0]    m_size,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  input  logic          m_addr_ok,
  input  logic          m_data_ok,
  input  logic [31:0]   m_rdata,
  output logic          arb_err
);

  arb_state_e state_q, state_d;
  logic       hold_q, hold_d;
  logic       arb_err_q, arb_err_d;
  logic       sel_id;
  logic       gnt_vld;
  logic       gnt_id;
  logic       fifo_push;
  logic       fifo_reserve;
  logic       fifo_dout;
  logic       fifo_full;
  logic       fifo_empty;

`ifdef ARB_RR_EN
  logic last_q, last_d;

  // Round-robin pick: on a tie the port not granted last wins.
  always_comb begin
    if (i_req && d_req) begin
      sel_id = ~last_q;
    end else begin
      sel_id = d_req ? ARB_ID_DATA : ARB_ID_INST;
    end
  end

  // Last-grant tracking follows every push into the order FIFO.
  always_comb begin
    last_d = last_q;
    if (fifo_push) begin
      last_d = gnt_id;
    end
  end

  // Last-grant register; resets to data so instruction wins the first tie.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_q <= ARB_ID_DATA;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed priority: data beats instruction.
  always_comb begin
    sel_id = d_req ? ARB_ID_DATA : ARB_ID_INST;
  end
`endif

  // Grant FSM next-state: pick a winner in IDLE, keep it in HOLD.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    gnt_vld      = 1'b0;
    gnt_id       = hold_q;
    fifo_push    = 1'b0;
    fifo_reserve = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (!fifo_full && (i_req || d_req)) begin
          gnt_vld = 1'b1;
          gnt_id  = sel_id;
          if (m_addr_ok) begin
            fifo_push = 1'b1;
          end else begin
            fifo_reserve = 1'b1;
            hold_d       = sel_id;
            state_d      = ARB_HOLD;
          end
        end
      end
      ARB_HOLD: begin
        gnt_vld = 1'b1;
        gnt_id  = hold_q;
        if (m_addr_ok) begin
          fifo_push = 1'b1;
          state_d   = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Sticky error: a response arrived with nothing outstanding.
  always_comb begin
    arb_err_d = arb_err_q | (m_data_ok & fifo_empty);
  end

  // FSM, held-grant id and error flag registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ARB_IDLE;
      hold_q    <= ARB_ID_INST;
      arb_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      arb_err_q <= arb_err_d;
    end
  end

  arb_order_fifo #(
    .OUTST_DEPTH(OUTST_DEPTH)
  ) u_order_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (fifo_push),
    .pop    (m_data_ok),
    .din    (gnt_id),
    .reserve(fifo_reserve),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Downstream request mux; everything is silenced while in reset.
  assign m_req   = resetn & gnt_vld;
  assign m_wr    = (gnt_id == ARB_ID_DATA) ? d_wr    : 1'b0;
  assign m_size  = (gnt_id == ARB_ID_DATA) ? d_size  : ARB_INST_SIZE;
  assign m_addr  = (gnt_id == ARB_ID_DATA) ? d_addr  : i_addr;
  assign m_wdata = (gnt_id == ARB_ID_DATA) ? d_wdata : 32'd0;

  assign i_addr_ok = m_req & m_addr_ok & (gnt_id == ARB_ID_INST);
  assign d_addr_ok = m_req & m_addr_ok & (gnt_id == ARB_ID_DATA);

  // Responses go to the port recorded at the FIFO head.
  assign i_data_ok = resetn & m_data_ok & ~fifo_empty & (fifo_dout == ARB_ID_INST);
  assign d_data_ok = resetn & m_data_ok & ~fifo_empty & (fifo_dout == ARB_ID_DATA);
  assign i_rdata   = m_rdata;
  assign d_rdata   = m_rdata;

  assign arb_err = arb_err_q;

endmodule
